// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses to a word-wide, big-endian data memory.
// Optional `LSU_MISALIGN_TRAP_EN` reports misaligned half/word accesses instead of performing them.
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        isStore,
    input  logic [1:0]  size,
    input  logic        unsignedLoad,
    input  logic [31:0] addr,
    input  logic [31:0] storeData,
    output logic        busy,
    output logic        done,
    output logic [31:0] loadData,
    output logic        misaligned,
    output logic [31:0] memAddress,
    output logic        memRead,
    output logic        memWrite,
    output logic [31:0] memWriteData,
    input  logic [31:0] memReadData
);

    localparam int unsigned DW = 32;
    localparam int unsigned HW = 16;
    localparam int unsigned BW = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            is_store_q, is_store_d;
    logic [1:0]      size_q, size_d;
    logic            unsigned_q, unsigned_d;
    logic [DW-1:0]   addr_q, addr_d;
    logic [HW-1:0]   store_data_q, store_data_d;
    logic [DW-1:0]   load_data_q, load_data_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            trap_c;
    logic [BW-1:0]   lane_byte_c;
    logic [HW-1:0]   lane_half_c;
    logic [DW-1:0]   fmt_load_c;
    logic [DW-1:0]   merged_c;

`ifdef LSU_MISALIGN_TRAP_EN
    logic            misaligned_q, misaligned_d;

    assign trap_c = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));

    always_comb begin
        misaligned_d = (state_q == S_IDLE) && start && trap_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misaligned_q <= 1'b0;
        else        misaligned_q <= misaligned_d;
    end

    assign misaligned = misaligned_q;
`else
    assign trap_c     = 1'b0;
    assign misaligned = 1'b0;
`endif

    // Lane extraction and merge over the captured memory word (offset 0 = MSB lane).
    always_comb begin
        lane_byte_c = memReadData[31:24];
        case (addr_q[1:0])
            2'd1:    lane_byte_c = memReadData[23:16];
            2'd2:    lane_byte_c = memReadData[15:8];
            2'd3:    lane_byte_c = memReadData[7:0];
            default: lane_byte_c = memReadData[31:24];
        endcase
        lane_half_c = addr_q[1] ? memReadData[15:0] : memReadData[31:16];

        case (size_q)
            2'b00:   fmt_load_c = {{(DW-BW){~unsigned_q & lane_byte_c[BW-1]}}, lane_byte_c};
            2'b01:   fmt_load_c = {{(DW-HW){~unsigned_q & lane_half_c[HW-1]}}, lane_half_c};
            default: fmt_load_c = memReadData;
        endcase

        merged_c = memReadData;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'd0:    merged_c[31:24] = store_data_q[BW-1:0];
                2'd1:    merged_c[23:16] = store_data_q[BW-1:0];
                2'd2:    merged_c[15:8]  = store_data_q[BW-1:0];
                default: merged_c[7:0]   = store_data_q[BW-1:0];
            endcase
        end else if (size_q == 2'b01) begin
            if (addr_q[1]) merged_c[15:0]  = store_data_q;
            else           merged_c[31:16] = store_data_q;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        is_store_d   = is_store_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        addr_d       = addr_q;
        store_data_d = store_data_q;
        load_data_d  = load_data_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_store_d   = isStore;
                    size_d       = size;
                    unsigned_d   = unsignedLoad;
                    addr_d       = addr;
                    store_data_d = storeData[HW-1:0];
                    if (trap_c) begin
                        state_d = S_DONE;
                    end else if (!isStore) begin
                        state_d = S_RD;
                    end else if (size[1]) begin
                        state_d     = S_WR;
                        mem_wdata_d = storeData;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: state_d = S_CAP;
            S_CAP: begin
                if (is_store_q) begin
                    mem_wdata_d = merged_c;
                    state_d     = S_WR;
                end else begin
                    load_data_d = fmt_load_c;
                    state_d     = S_DONE;
                end
            end
            S_WR:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            is_store_q   <= 1'b0;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            addr_q       <= '0;
            store_data_q <= '0;
            load_data_q  <= '0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_store_q   <= is_store_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            addr_q       <= addr_d;
            store_data_q <= store_data_d;
            load_data_q  <= load_data_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign loadData     = load_data_q;
    assign memWriteData = mem_wdata_q;
    assign memAddress   = {addr_q[31:2], 2'b00};
    assign memRead      = (state_q == S_RD);
    assign memWrite     = (state_q == S_WR);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: memory model, per-cycle output checker and access-level model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        isStore = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        unsignedLoad = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] storeData = '0;
    logic        busy, done, misaligned, memRead, memWrite;
    logic [31:0] loadData, memAddress, memWriteData;
    logic [31:0] memReadData = '0;

    logic [31:0] mem [16];

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;

    logic [31:0] model_load = '0;
    logic [31:0] pend_load = '0;
    logic [31:0] pend_wdata = '0;
    logic [31:0] pend_addr = '0;
    logic        pend_mis = 1'b0;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .isStore(isStore), .size(size),
        .unsignedLoad(unsignedLoad), .addr(addr), .storeData(storeData),
        .busy(busy), .done(done), .loadData(loadData), .misaligned(misaligned),
        .memAddress(memAddress), .memRead(memRead), .memWrite(memWrite),
        .memWriteData(memWriteData), .memReadData(memReadData)
    );

    always #5 clk = ~clk;

    // Synchronous data memory: read data appears the cycle after memRead is sampled.
    always @(posedge clk) begin
        if (memRead)  memReadData <= mem[memAddress[5:2]];
        if (memWrite) mem[memAddress[5:2]] <= memWriteData;
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Per-cycle output checker against the access-level model.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs", {busy, done, misaligned, memRead, memWrite, loadData, memWriteData}, '0);
            model_load = '0;
        end else begin
            chk("strobe_exclusive", {95'd0, memRead & memWrite}, '0);
            if (memRead) begin
                rd_cnt++;
                chk("rd_address", {64'd0, memAddress}, {64'd0, pend_addr});
            end
            if (memWrite) begin
                wr_cnt++;
                chk("wr_address", {64'd0, memAddress}, {64'd0, pend_addr});
                chk("wr_data", {64'd0, memWriteData}, {64'd0, pend_wdata});
            end
            if (done) begin
                chk("done_busy", {95'd0, busy}, 96'd1);
                chk("done_load", {64'd0, loadData}, {64'd0, pend_load});
                chk("done_misaligned", {95'd0, misaligned}, {95'd0, pend_mis});
                model_load = pend_load;
            end else if (!busy) begin
                chk("idle_load", {64'd0, loadData}, {64'd0, model_load});
                chk("idle_strobes", {94'd0, memRead, memWrite}, '0);
            end
        end
    end

    // Issue one access, predict its outcome from the memory contents, and measure latency.
    task automatic op(input string name, input logic st, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] sd, output int lat);
        logic [31:0] word;
        logic [63:0] v, mask;
        int nb, off, sh, exp_n, exp_rd, exp_wr, rd0, wr0;
        logic trap, got;
        word = mem[a[5:2]];
`ifdef LSU_MISALIGN_TRAP_EN
        trap = ((sz == 2'd1) && a[0]) || ((sz >= 2'd2) && (a[1:0] != 2'd0));
`else
        trap = 1'b0;
`endif
        nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off  = (nb == 1) ? int'(a[1:0]) : (nb == 2) ? 2 * int'(a[1]) : 0;
        sh   = 8 * (4 - nb - off);
        mask = (64'd1 << (8 * nb)) - 64'd1;
        pend_addr  = {a[31:2], 2'b00};
        pend_mis   = trap;
        pend_load  = model_load;
        pend_wdata = '0;
        if (trap) begin
            exp_n = 1; exp_rd = 0; exp_wr = 0;
        end else if (st) begin
            v = ({32'd0, word} & ~(mask << sh)) | (({32'd0, sd} & mask) << sh);
            pend_wdata = (nb == 4) ? sd : v[31:0];
            exp_n  = (nb == 4) ? 2 : 4;
            exp_rd = (nb == 4) ? 0 : 1;
            exp_wr = 1;
        end else begin
            v = ({32'd0, word} >> sh) & mask;
            if (!uns && nb < 4 && v >= (mask + 64'd1) / 2) v = v - (mask + 64'd1);
            pend_load = v[31:0];
            exp_n = 3; exp_rd = 1; exp_wr = 0;
        end

        @(posedge clk); #1;
        rd0 = rd_cnt; wr0 = wr_cnt;
        start = 1'b1; isStore = st; size = sz; unsignedLoad = uns; addr = a; storeData = sd;
        @(posedge clk); #1;
        start = 1'b0;
        isStore = ~st; size = ~sz; addr = ~a; storeData = ~sd;
        lat = 1; got = 1'b0;
        while (lat <= 8 && !got) begin
            #5;
            if (done) got = 1'b1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        if (!got) chk({name, "_timeout"}, 96'd0, 96'd1);
        chk({name, "_latency"}, 96'(lat), 96'(exp_n));
        chk({name, "_reads"}, 96'(rd_cnt - rd0), 96'(exp_rd));
        chk({name, "_writes"}, 96'(wr_cnt - wr0), 96'(exp_wr));
    endtask

    int lat;
    int wr_before;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[4] = 32'h80FF7F01;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_busy", {95'd0, busy}, '0);

        op("lb_10", 1'b0, 2'd0, 1'b0, 32'h10, 32'h0, lat);
        chk("lb_10_value", {64'd0, loadData}, {64'd0, 32'hFFFFFF80});
        chk("lb_10_lat", 96'(lat), 96'd3);
        op("lbu_11", 1'b0, 2'd0, 1'b1, 32'h11, 32'h0, lat);
        chk("lbu_11_value", {64'd0, loadData}, {64'd0, 32'h000000FF});
        op("lh_12", 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, lat);
        chk("lh_12_value", {64'd0, loadData}, {64'd0, 32'h00007F01});
        op("lh_10", 1'b0, 2'd1, 1'b0, 32'h10, 32'h0, lat);
        chk("lh_10_value", {64'd0, loadData}, {64'd0, 32'hFFFF80FF});
        op("lhu_10", 1'b0, 2'd1, 1'b1, 32'h10, 32'h0, lat);
        chk("lhu_10_value", {64'd0, loadData}, {64'd0, 32'h000080FF});
        op("lb_13", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, lat);
        chk("lb_13_value", {64'd0, loadData}, {64'd0, 32'h00000001});

        op("lw_12", 1'b0, 2'd2, 1'b0, 32'h12, 32'h0, lat);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lw_12_misaligned", {95'd0, misaligned}, 96'd1);
        chk("lw_12_lat", 96'(lat), 96'd1);
`else
        chk("lw_12_value", {64'd0, loadData}, {64'd0, 32'h80FF7F01});
        chk("lw_12_lat", 96'(lat), 96'd3);
`endif

        op("sb_13", 1'b1, 2'd0, 1'b0, 32'h13, 32'h000000AA, lat);
        chk("sb_13_mem", {64'd0, mem[4]}, {64'd0, 32'h80FF7FAA});
        chk("sb_13_lat", 96'(lat), 96'd4);
        op("sw_10", 1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678, lat);
        chk("sw_10_mem", {64'd0, mem[4]}, {64'd0, 32'h12345678});
        chk("sw_10_lat", 96'(lat), 96'd2);
        op("sh_12", 1'b1, 2'd1, 1'b0, 32'h12, 32'h0000CAFE, lat);
        chk("sh_12_mem", {64'd0, mem[4]}, {64'd0, 32'h1234CAFE});
        op("lh_12b", 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, lat);
        chk("lh_12b_value", {64'd0, loadData}, {64'd0, 32'hFFFFCAFE});
        op("sb_10", 1'b1, 2'd0, 1'b0, 32'h10, 32'hFFFFFF99, lat);
        chk("sb_10_mem", {64'd0, mem[4]}, {64'd0, 32'h9934CAFE});
        op("lbu_10", 1'b0, 2'd0, 1'b1, 32'h10, 32'h0, lat);
        chk("lbu_10_value", {64'd0, loadData}, {64'd0, 32'h00000099});

        // Half store abandoned by a reset pulse while the read word is being captured.
        @(posedge clk); #1;
        wr_before = wr_cnt;
        pend_addr = 32'h10; pend_load = model_load; pend_mis = 1'b0; pend_wdata = 32'h0;
        start = 1'b1; isStore = 1'b1; size = 2'd1; unsignedLoad = 1'b0; addr = 32'h10; storeData = 32'h0000BEEF;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {91'd0, busy, done, misaligned, memRead, memWrite}, '0);
        chk("midrst_data", {32'd0, loadData, memWriteData}, '0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_write", 96'(wr_cnt - wr_before), 96'd0);
        chk("midrst_mem", {64'd0, mem[4]}, {64'd0, 32'h9934CAFE});

        op("lw_after_rst", 1'b0, 2'd3, 1'b0, 32'h10, 32'h0, lat);
        chk("lw_after_rst_value", {64'd0, loadData}, {64'd0, 32'h9934CAFE});

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
